// File: rtl/uart_tx_fifo_if.sv
// Host/transmitter-side signal bundle for uart_tx_fifo.
// master = host/bench side, slave = the FIFO itself.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 3
);
  // wr_en is a one-cycle enqueue strobe with no ready: the byte is taken when
  // !full, or when a pop happens on the same edge. It is silently dropped otherwise.
  // read_enable is an active-low load strobe and bus_value is valid while it is low.
  logic              ticker;
  logic [7:0]        wr_data;
  logic              wr_en;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic [7:0]        bus_value;
  logic              read_enable;
  logic              busy;
  logic [1:0]        dbg_state;

  modport master (
    output ticker, wr_data, wr_en,
    input  full, empty, count, bus_value, read_enable, busy, dbg_state
  );

  modport slave (
    input  ticker, wr_data, wr_en,
    output full, empty, count, bus_value, read_enable, busy, dbg_state
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO ahead of a UART transmitter; pops one byte per serial frame paced by ticker.
// Define UART_TX_FIFO_OVF_EN to add the sticky overflow output.
module uart_tx_fifo #(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int LOAD_TICKS  = 2,
  parameter int FRAME_TICKS = 12
) (
  input  logic          clock,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic          overflow
`endif
);
  localparam int TMAX   = (LOAD_TICKS > FRAME_TICKS) ? LOAD_TICKS : FRAME_TICKS;
  localparam int TCNT_W = $clog2(TMAX + 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [TCNT_W-1:0] LOAD_END  = TCNT_W'(LOAD_TICKS);
  localparam logic [TCNT_W-1:0] FRAME_END = TCNT_W'(FRAME_TICKS);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FRAME = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic [7:0]        bus_value_q, bus_value_d;
  logic              read_enable_q, read_enable_d;
  logic              busy_q, busy_d;
  logic              ticker_q;
  logic [7:0]        mem [DEPTH];
  logic              tick_rise, pop, wr_ok;

  assign tick_rise = bus.ticker & ~ticker_q;
  assign pop       = (state_q == IDLE) && !empty_q;
  // A full FIFO still accepts a write on the edge that frees a slot.
  assign wr_ok     = bus.wr_en && (!full_q || pop);
  assign tcnt_inc  = tcnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    rd_ptr_d      = rd_ptr_q;
    bus_value_d   = bus_value_q;
    read_enable_d = read_enable_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          bus_value_d   = mem[rd_ptr_q];
          rd_ptr_d      = rd_ptr_q + 1'b1;
          read_enable_d = 1'b0;
          tcnt_d        = '0;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        if (tick_rise) begin
          if (tcnt_inc == LOAD_END) begin
            read_enable_d = 1'b1;
            tcnt_d        = '0;
            state_d       = FRAME;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
      end
      FRAME: begin
        if (tick_rise) begin
          if (tcnt_inc == FRAME_END) begin
            tcnt_d  = '0;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tcnt_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      bus_value_q   <= '0;
      read_enable_q <= 1'b1;
      busy_q        <= 1'b0;
      ticker_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      bus_value_q   <= bus_value_d;
      read_enable_q <= read_enable_d;
      busy_q        <= busy_d;
      ticker_q      <= bus.ticker;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr_q] <= bus.wr_data;
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   ovf_q <= 1'b0;
    else if (bus.wr_en && !wr_ok) ovf_q <= 1'b1;
  end
  assign overflow = ovf_q;
`endif

  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.count       = count_q;
  assign bus.bus_value   = bus_value_q;
  assign bus.read_enable = read_enable_q;
  assign bus.busy        = busy_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of bytes against observed load strobes.
module tb_uart_tx_fifo;
  localparam int DEPTH = 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_tx_fifo_if ifc ();
`ifdef UART_TX_FIFO_OVF_EN
  logic overflow;
`endif

  uart_tx_fifo dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_t_q[$];
  int         total = 0;
  int         bad = 0;
  int         tick_since = 0;
  int         rise_ticks = -1;
  int         fall_ticks = -1;
  bit         tick_run = 1'b1;
  bit         re_p = 1'b1;
  bit         busy_p = 1'b0;

  // ticker: square wave, 3 clocks per half period, can be frozen
  initial begin
    ifc.ticker = 1'b0;
    forever begin
      repeat (3) @(posedge clock);
      #2;
      if (tick_run) begin
        ifc.ticker = ~ifc.ticker;
        if (ifc.ticker) tick_since++;
      end
    end
  end

  // monitor: records every load strobe and tick counts around it
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (re_p && !ifc.read_enable) begin
        obs_q.push_back(ifc.bus_value);
        obs_t_q.push_back(tick_since);
        tick_since = 0;
      end
      if (!re_p && ifc.read_enable) rise_ticks = tick_since;
      if (busy_p && !ifc.busy) fall_ticks = tick_since;
      re_p   = ifc.read_enable;
      busy_p = ifc.busy;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #3;
  endtask

  task automatic write_byte(input logic [7:0] d);
    ifc.wr_en   = 1'b1;
    ifc.wr_data = d;
    step();
    ifc.wr_en   = 1'b0;
  endtask

  task automatic pop_pair(output bit got, output logic [7:0] act, output logic [7:0] exp,
                          output int ticks);
    got = 1'b0; act = '0; exp = '0; ticks = 0;
    for (int i = 0; i < 400 && obs_q.size() == 0; i++) step();
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      got   = 1'b1;
      act   = obs_q.pop_front();
      ticks = obs_t_q.pop_front();
      exp   = exp_q.pop_front();
    end
  endtask

  task automatic wait_idle(output bit got);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      if (!ifc.busy) got = 1'b1;
    end
  endtask

  // tests
  task automatic test_reset();
    ifc.wr_en = 1'b0; ifc.wr_data = '0; reset = 1'b1;
    repeat (3) step();
    total++;
    if (ifc.read_enable !== 1'b1 || ifc.empty !== 1'b1 || ifc.full !== 1'b0 ||
        ifc.count !== 4'd0 || ifc.busy !== 1'b0 || ifc.bus_value !== 8'd0) begin
      bad++;
      $display("FAIL reset_values: re=%b empty=%b full=%b count=%0d busy=%b bus=%0d, need 1 1 0 0 0 0",
               ifc.read_enable, ifc.empty, ifc.full, ifc.count, ifc.busy, ifc.bus_value);
    end
`ifdef UART_TX_FIFO_OVF_EN
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b need 0", overflow); end
`endif
    reset = 1'b0;
    step();
    write_byte(8'h77);
    exp_q.push_back(8'h77);
    step();
    total++;
    if (ifc.read_enable !== 1'b0 || ifc.dbg_state !== 2'd1) begin
      bad++;
      $display("FAIL reset_setup_load: re=%b state=%0d need 0 1", ifc.read_enable, ifc.dbg_state);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (ifc.read_enable !== 1'b1 || ifc.empty !== 1'b1 || ifc.count !== 4'd0 ||
        ifc.busy !== 1'b0 || ifc.bus_value !== 8'd0) begin
      bad++;
      $display("FAIL reset_mid_load: re=%b empty=%b count=%0d busy=%b bus=%0d, need 1 1 0 0 0",
               ifc.read_enable, ifc.empty, ifc.count, ifc.busy, ifc.bus_value);
    end
    #2 reset = 1'b0;
    exp_q.delete(); obs_q.delete(); obs_t_q.delete();
    step();
  endtask

  task automatic test_single_byte();
    bit got; logic [7:0] a, e; int t;
    rise_ticks = -1; fall_ticks = -1;
    write_byte(8'd12);
    exp_q.push_back(8'd12);
    total++;
    if (ifc.read_enable !== 1'b1 || ifc.count !== 4'd1 || ifc.empty !== 1'b0) begin
      bad++;
      $display("FAIL single_after_write: re=%b count=%0d empty=%b need 1 1 0",
               ifc.read_enable, ifc.count, ifc.empty);
    end
    step();
    total++;
    if (ifc.read_enable !== 1'b0 || ifc.bus_value !== 8'd12 || ifc.busy !== 1'b1) begin
      bad++;
      $display("FAIL single_latency: re=%b bus=%0d busy=%b need 0 12 1",
               ifc.read_enable, ifc.bus_value, ifc.busy);
    end
    pop_pair(got, a, e, t);
    total++;
    if (!got || a !== e) begin bad++; $display("FAIL single_value: got %0d need %0d (seen=%b)", a, e, got); end
    wait_idle(got);
    total++;
    if (!got || rise_ticks != 2 || fall_ticks != 14) begin
      bad++;
      $display("FAIL single_timing: low_ticks=%0d busy_ticks=%0d idle=%b need 2 14 1",
               rise_ticks, fall_ticks, got);
    end
  endtask

  task automatic test_ordering();
    logic [7:0] seq [5];
    bit got; logic [7:0] a, e; int t;
    seq = '{8'd12, 8'd45, 8'd9, 8'd67, 8'd101};
    foreach (seq[i]) begin
      write_byte(seq[i]);
      exp_q.push_back(seq[i]);
    end
    for (int k = 0; k < 5; k++) begin
      pop_pair(got, a, e, t);
      total++;
      if (!got || a !== e) begin bad++; $display("FAIL order_value[%0d]: got %0d need %0d (seen=%b)", k, a, e, got); end
      if (k > 0) begin
        total++;
        if (t != 14) begin bad++; $display("FAIL order_spacing[%0d]: got %0d ticks need 14", k, t); end
      end
    end
  endtask

  task automatic test_full_wrap();
    bit got; logic [7:0] a, e; int t;
    write_byte(8'hEE);
    exp_q.push_back(8'hEE);
    pop_pair(got, a, e, t);
    total++;
    if (!got || a !== e) begin bad++; $display("FAIL full_lead: got %0d need %0d (seen=%b)", a, e, got); end
    for (int i = 0; i < 9; i++) begin
      write_byte(8'(i));
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
      if (i == 7 || i == 8) begin
        total++;
        if (ifc.full !== 1'b1 || ifc.count !== 4'd8) begin
          bad++;
          $display("FAIL full_flag[%0d]: full=%b count=%0d need 1 8", i, ifc.full, ifc.count);
        end
      end
    end
    step();
`ifdef UART_TX_FIFO_OVF_EN
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow: got %b need 1", overflow); end
`endif
    for (int k = 0; k < DEPTH; k++) begin
      pop_pair(got, a, e, t);
      total++;
      if (!got || a !== e) begin bad++; $display("FAIL full_drain[%0d]: got %0d need %0d (seen=%b)", k, a, e, got); end
    end
    total++;
    if (ifc.empty !== 1'b1) begin bad++; $display("FAIL full_empty_after: got %b need 1", ifc.empty); end
    wait_idle(got);
  endtask

  task automatic test_simultaneous();
    bit got; logic [7:0] a, e, r; int t;
    write_byte(8'h3C);
    exp_q.push_back(8'h3C);
    pop_pair(got, a, e, t);
    total++;
    if (!got || a !== e) begin bad++; $display("FAIL simul_lead: got %0d need %0d (seen=%b)", a, e, got); end
    for (int i = 0; i < DEPTH; i++) begin
      r = 8'($urandom_range(0, 255));
      write_byte(r);
      exp_q.push_back(r);
    end
    wait_idle(got);
    total++;
    if (!got || ifc.full !== 1'b1 || ifc.dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL simul_setup: idle=%b full=%b state=%0d need 1 1 0", got, ifc.full, ifc.dbg_state);
    end
    ifc.wr_en = 1'b1; ifc.wr_data = 8'hA5;
    exp_q.push_back(8'hA5);
    step();
    ifc.wr_en = 1'b0;
    total++;
    if (ifc.count !== 4'd8 || ifc.full !== 1'b1 || ifc.read_enable !== 1'b0) begin
      bad++;
      $display("FAIL simul_count: count=%0d full=%b re=%b need 8 1 0", ifc.count, ifc.full, ifc.read_enable);
    end
    for (int k = 0; k < DEPTH + 1; k++) begin
      pop_pair(got, a, e, t);
      total++;
      if (!got || a !== e) begin bad++; $display("FAIL simul_drain[%0d]: got %0h need %0h (seen=%b)", k, a, e, got); end
    end
    wait_idle(got);
  endtask

  task automatic test_ticker_hold();
    bit got; logic [7:0] a, e; int t; int odd;
    tick_run = 1'b0;
    write_byte(8'h5A);
    exp_q.push_back(8'h5A);
    pop_pair(got, a, e, t);
    total++;
    if (!got || a !== e) begin bad++; $display("FAIL hold_value: got %0h need %0h (seen=%b)", a, e, got); end
    odd = 0;
    repeat (200) begin
      step();
      if (ifc.read_enable !== 1'b0 || ifc.dbg_state !== 2'd1) odd++;
    end
    total++;
    if (odd != 0) begin bad++; $display("FAIL hold_load: %0d cycles left LOAD, need 0", odd); end
    tick_run = 1'b1;
    wait_idle(got);
    total++;
    if (!got || ifc.read_enable !== 1'b1) begin
      bad++;
      $display("FAIL hold_resume: idle=%b re=%b need 1 1", got, ifc.read_enable);
    end
  endtask

  initial begin
    ifc.wr_en = 1'b0;
    ifc.wr_data = '0;
    test_reset();
    test_single_byte();
    test_ordering();
    test_full_wrap();
    test_simultaneous();
    test_ticker_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
